// File: rtl/pifo_reg_slots.sv
// pifo_reg_slots
//
// Slot storage for the PIFO register. Holds REG_WIDTH rank entries with
// per-slot valid bits and drives the flattened data/index/valid bus that the
// pairwise max reduction tree reads. This block is the only agent that sets
// or clears slot valid bits:
//   - Inserts use a valid/ready handshake and land in the lowest free slot.
//   - Removals name the slot index that the tree selected.
//
// Ports:
//   clk, rst      single clock; asynchronous active-high reset
//   ins_data      rank to insert
//   ins_valid     insert request
//   ins_ready     a slot is free (equals !full)
//   rem_valid     one-cycle removal request
//   rem_idx       slot to clear
//   data_out      slot i rank at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   idx_out       slot i field holds the constant i
//   vld_out       bit i set when slot i is occupied
//   count         number of occupied slots, 0..REG_WIDTH
//   full, empty   derived from count
//   rem_err       one-cycle pulse; a removal targeted an empty slot
//
// Optional feature, enabled by defining PIFO_REG_SLOTS_STATS_EN:
//   ins_cnt       saturating count of accepted inserts
//   rem_err_cnt   saturating count of rem_err pulses
// Without the macro these ports and their registers are absent.

module pifo_reg_slots #(
  parameter int REG_WIDTH  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           ins_data,
  input  logic                            ins_valid,
  output logic                            ins_ready,
  input  logic                            rem_valid,
  input  logic [IDX_WIDTH-1:0]            rem_idx,
  output logic [REG_WIDTH*DATA_WIDTH-1:0] data_out,
  output logic [REG_WIDTH*IDX_WIDTH-1:0]  idx_out,
  output logic [REG_WIDTH-1:0]            vld_out,
  output logic [IDX_WIDTH:0]              count,
  output logic                            full,
  output logic                            empty,
`ifdef PIFO_REG_SLOTS_STATS_EN
  output logic                            rem_err,
  output logic [15:0]                     ins_cnt,
  output logic [15:0]                     rem_err_cnt
`else
  output logic                            rem_err
`endif
);

  logic [IDX_WIDTH-1:0] free_idx;
  logic                 ins_fire;
  logic                 rem_ok;
  logic                 rem_bad;

  // The index bus is plain wiring, so the tree receives a self-describing bus.
  for (genvar g = 0; g < REG_WIDTH; g++) begin : g_idx
    assign idx_out[g*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(g);
  end

  // Status flags come straight from the occupancy count.
  assign full      = (count == (IDX_WIDTH+1)'(REG_WIDTH));
  assign empty     = (count == '0);
  assign ins_ready = !full;

  // Find the lowest free slot. The scan runs from the top down, so the last
  // match it records is the lowest index. The scan uses registered state
  // only, which is why a slot being removed this cycle is never chosen.
  always_comb begin
    free_idx = '0;
    for (int i = REG_WIDTH - 1; i >= 0; i--) begin
      if (!vld_out[i]) begin
        free_idx = IDX_WIDTH'(i);
      end
    end
  end

  // An insert needs a free slot. A removal is legal only on an occupied slot.
  assign ins_fire = ins_valid && ins_ready;
  assign rem_ok   = rem_valid && vld_out[rem_idx];
  assign rem_bad  = rem_valid && !vld_out[rem_idx];

  // Slot contents, valid bits, count and the error pulse.
  // - A removal clears only the valid bit; the stale rank stays in place
  //   because the tree ignores invalid slots.
  // - An insert and a removal can never target the same slot, so both valid
  //   bit updates can apply in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      vld_out  <= '0;
      count    <= '0;
      rem_err  <= 1'b0;
    end else begin
      rem_err <= rem_bad;
      if (ins_fire) begin
        data_out[free_idx*DATA_WIDTH +: DATA_WIDTH] <= ins_data;
        vld_out[free_idx] <= 1'b1;
      end
      if (rem_ok) begin
        vld_out[rem_idx] <= 1'b0;
      end
      case ({ins_fire, rem_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PIFO_REG_SLOTS_STATS_EN
  // Saturating statistics counters; they hold at 0xFFFF instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_cnt     <= '0;
      rem_err_cnt <= '0;
    end else begin
      if (ins_fire && ins_cnt != 16'hFFFF) begin
        ins_cnt <= ins_cnt + 16'd1;
      end
      if (rem_err && rem_err_cnt != 16'hFFFF) begin
        rem_err_cnt <= rem_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pifo_reg_slots.sv
// tb_pifo_reg_slots
//
// Directed bench for pifo_reg_slots with the default 4 x 8-bit slots.
// - Inputs change on the falling edge.
// - Results are checked on the following falling edge, half a cycle after
//   the rising edge that consumed the inputs.
// - Every expected value is written down by hand.

module tb_pifo_reg_slots;

  logic        clk;
  logic        rst;
  logic [7:0]  ins_data;
  logic        ins_valid;
  logic        ins_ready;
  logic        rem_valid;
  logic [1:0]  rem_idx;
  logic [31:0] data_out;
  logic [7:0]  idx_out;
  logic [3:0]  vld_out;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        rem_err;
`ifdef PIFO_REG_SLOTS_STATS_EN
  logic [15:0] ins_cnt;
  logic [15:0] rem_err_cnt;
`endif

  int num_checks;
  int num_fails;

  pifo_reg_slots #(
    .REG_WIDTH (4),
    .IDX_WIDTH (2),
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_data   (ins_data),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .rem_valid  (rem_valid),
    .rem_idx    (rem_idx),
    .data_out   (data_out),
    .idx_out    (idx_out),
    .vld_out    (vld_out),
    .count      (count),
    .full       (full),
    .empty      (empty),
`ifdef PIFO_REG_SLOTS_STATS_EN
    .rem_err    (rem_err),
    .ins_cnt    (ins_cnt),
    .rem_err_cnt(rem_err_cnt)
`else
    .rem_err    (rem_err)
`endif
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one cycle of requests from a falling edge, let the rising edge
  // consume them, and return on the next falling edge with inputs idle.
  task automatic applyStimulus(input logic iv, input logic [7:0] id,
                               input logic rv, input logic [1:0] ri);
    ins_valid = iv;
    ins_data  = id;
    rem_valid = rv;
    rem_idx   = ri;
    @(negedge clk);
    ins_valid = 1'b0;
    rem_valid = 1'b0;
  endtask

  initial begin
    num_checks = 0;
    num_fails  = 0;
    ins_valid  = 1'b0;
    ins_data   = 8'h00;
    rem_valid  = 1'b0;
    rem_idx    = 2'd0;
    rst        = 1'b1;
    #12;

    // Reset state.
    checkOutput("rst_vld",   32'(vld_out),   32'h0);
    checkOutput("rst_data",  data_out,       32'h0);
    checkOutput("rst_count", 32'(count),     32'h0);
    checkOutput("rst_full",  32'(full),      32'h0);
    checkOutput("rst_empty", 32'(empty),     32'h1);
    checkOutput("rst_ready", 32'(ins_ready), 32'h1);
    checkOutput("rst_err",   32'(rem_err),   32'h0);
    checkOutput("rst_idx",   32'(idx_out),   32'he4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill all four slots with back-to-back inserts.
    applyStimulus(1'b1, 8'h10, 1'b0, 2'd0);
    checkOutput("ins1_count", 32'(count), 32'h1);
    checkOutput("ins1_empty", 32'(empty), 32'h0);
    applyStimulus(1'b1, 8'h20, 1'b0, 2'd0);
    applyStimulus(1'b1, 8'h30, 1'b0, 2'd0);
    applyStimulus(1'b1, 8'h40, 1'b0, 2'd0);
    checkOutput("fill_data",  data_out,       32'h40302010);
    checkOutput("fill_vld",   32'(vld_out),   32'hf);
    checkOutput("fill_count", 32'(count),     32'h4);
    checkOutput("fill_full",  32'(full),      32'h1);
    checkOutput("fill_ready", 32'(ins_ready), 32'h0);

    // While full, hold an insert of 0x55: nothing may change.
    ins_valid = 1'b1;
    ins_data  = 8'h55;
    repeat (3) @(negedge clk);
    checkOutput("hold_data",  data_out,     32'h40302010);
    checkOutput("hold_count", 32'(count),   32'h4);
    checkOutput("hold_vld",   32'(vld_out), 32'hf);

    // Remove slot 2 with the insert still pending; no same-cycle reuse.
    rem_valid = 1'b1;
    rem_idx   = 2'd2;
    @(negedge clk);
    rem_valid = 1'b0;
    checkOutput("rem2_vld",   32'(vld_out),   32'hb);
    checkOutput("rem2_count", 32'(count),     32'h3);
    checkOutput("rem2_ready", 32'(ins_ready), 32'h1);
    @(negedge clk);
    ins_valid = 1'b0;
    checkOutput("refill_data",  data_out,     32'h40552010);
    checkOutput("refill_vld",   32'(vld_out), 32'hf);
    checkOutput("refill_count", 32'(count),   32'h4);

    // Slots {0,1,3} valid: insert 0x77 together with a removal of slot 0.
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd2);
    checkOutput("pre_vld", 32'(vld_out), 32'hb);
    applyStimulus(1'b1, 8'h77, 1'b1, 2'd0);
    checkOutput("both_data",  data_out,     32'h40772010);
    checkOutput("both_vld",   32'(vld_out), 32'he);
    checkOutput("both_count", 32'(count),   32'h3);

    // Drain, then remove from an empty register.
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd2);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd3);
    checkOutput("drain_count", 32'(count), 32'h0);
    checkOutput("drain_empty", 32'(empty), 32'h1);
    checkOutput("drain_err",   32'(rem_err), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd1);
    checkOutput("err_pulse", 32'(rem_err), 32'h1);
    checkOutput("err_count", 32'(count),   32'h0);
    @(negedge clk);
    checkOutput("err_clear", 32'(rem_err), 32'h0);
`ifdef PIFO_REG_SLOTS_STATS_EN
    checkOutput("stat_err_cnt", 32'(rem_err_cnt), 32'h1);
    checkOutput("stat_ins_cnt", 32'(ins_cnt),     32'h6);
`endif

    // Two entries, then an asynchronous reset pulse in the middle of a cycle.
    applyStimulus(1'b1, 8'haa, 1'b0, 2'd0);
    applyStimulus(1'b1, 8'hbb, 1'b0, 2'd0);
    checkOutput("two_vld", 32'(vld_out), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_vld",   32'(vld_out), 32'h0);
    checkOutput("arst_count", 32'(count),   32'h0);
    checkOutput("arst_empty", 32'(empty),   32'h1);
    #1;
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 8'h99, 1'b0, 2'd0);
    checkOutput("post_data",  data_out,     32'h00000099);
    checkOutput("post_vld",   32'(vld_out), 32'h1);
    checkOutput("post_count", 32'(count),   32'h1);

`ifdef PIFO_REG_SLOTS_STATS_EN
    // One entry lives in slot 0. Each cycle inserts into the other low slot
    // while removing the current one, so every cycle accepts one insert.
    begin
      logic [1:0] cur;
      cur = 2'd0;
      for (int k = 0; k < 70000; k++) begin
        applyStimulus(1'b1, 8'h5a, 1'b1, cur);
        cur = (cur == 2'd0) ? 2'd1 : 2'd0;
      end
    end
    checkOutput("sat_ins_cnt", 32'(ins_cnt), 32'hffff);
    checkOutput("sat_count",   32'(count),   32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             num_checks, num_fails);
    $finish;
  end

endmodule
